// File: rtl/edge_detector_ctrl.sv
// edge_detector_ctrl: Avalon-MM controlled sequencer that loads a frame, bursts it into an edge detector and forwards results.
// Optional level interrupt (and stored IRQ_EN bit) enabled by defining EDGE_CTRL_IRQ_EN.
module edge_detector_ctrl #(
  parameter int IMG_X_SIZE     = 3,
  parameter int IMG_Y_SIZE     = 3,
  parameter int OUT_PIXELS     = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  avs_address_i,
  input  logic        avs_write_i,
  input  logic [31:0] avs_writedata_i,
  input  logic        avs_read_i,
  output logic [31:0] avs_readdata_o,
  input  logic        snk_valid_i,
  input  logic [7:0]  snk_data_i,
  output logic        snk_ready_o,
  output logic        det_start_o,
  output logic [7:0]  det_pixel_o,
  input  logic        det_data_available_i,
  input  logic        det_valid_i,
  input  logic [7:0]  det_pixel_i,
  output logic        src_valid_o,
  output logic [7:0]  src_data_o,
  output logic        irq_o
);

  localparam int N     = IMG_X_SIZE * IMG_Y_SIZE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_BURST, S_WAIT_AVAIL, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pixLoaded_q, pixLoaded_d;
  logic [31:0]       resSent_q, resSent_d;
  logic [IDX_W-1:0]  burstIdx_q, burstIdx_d, burstIdxNext;
  logic [WD_W-1:0]   wdCnt_q, wdCnt_d;
  logic [7:0]        detPixel_q, detPixel_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              done_q, done_d, timeout_q, timeout_d;
  logic              setDone, setTimeout;
  logic [7:0]        buffer_q [N];

  logic ctrlWr, statWr, goReq, abortReq, loadBeat, irqEnBit, unusedWdata;

  assign ctrlWr       = avs_write_i && (avs_address_i == 2'd0);
  assign statWr       = avs_write_i && (avs_address_i == 2'd1);
  assign goReq        = ctrlWr && avs_writedata_i[0];
  assign abortReq     = ctrlWr && avs_writedata_i[1];
  assign loadBeat     = (state_q == S_LOAD) && snk_valid_i;
  assign burstIdxNext = burstIdx_q + IDX_W'(1);
  assign unusedWdata  = ^avs_writedata_i[31:3];

  always_comb begin
    state_d     = state_q;
    pixLoaded_d = pixLoaded_q;
    resSent_d   = resSent_q;
    burstIdx_d  = burstIdx_q;
    wdCnt_d     = '0;
    detPixel_d  = detPixel_q;
    setDone     = 1'b0;
    setTimeout  = 1'b0;
    snk_ready_o = 1'b0;
    det_start_o = 1'b0;
    src_valid_o = 1'b0;
    src_data_o  = 8'h00;
    case (state_q)
      S_IDLE: begin
        if (goReq && !abortReq) begin
          state_d     = S_LOAD;
          pixLoaded_d = '0;
          resSent_d   = '0;
        end
      end
      S_LOAD: begin
        snk_ready_o = 1'b1;
        if (snk_valid_i) begin
          pixLoaded_d = pixLoaded_q + 32'd1;
          if (pixLoaded_q == 32'(N - 1)) state_d = S_START;
        end
      end
      S_START: begin
        // Preload the first pixel so it appears on the first BURST cycle.
        det_start_o = 1'b1;
        detPixel_d  = buffer_q[0];
        burstIdx_d  = '0;
        state_d     = S_BURST;
      end
      S_BURST: begin
        if (burstIdx_q == IDX_W'(N - 1)) begin
          state_d = S_WAIT_AVAIL;
        end else begin
          burstIdx_d = burstIdxNext;
          detPixel_d = buffer_q[burstIdxNext];
        end
      end
      S_WAIT_AVAIL: begin
        wdCnt_d = wdCnt_q + WD_W'(1);
        if (det_data_available_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        wdCnt_d = wdCnt_q + WD_W'(1);
        if (det_valid_i) begin
          src_valid_o = 1'b1;
          src_data_o  = det_pixel_i;
          resSent_d   = resSent_q + 32'd1;
          if (resSent_q == 32'(OUT_PIXELS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        setDone = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (((state_q == S_WAIT_AVAIL) || (state_q == S_DRAIN)) &&
        (wdCnt_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
      setTimeout = 1'b1;
      state_d    = S_IDLE;
    end
    if (abortReq) begin
      setDone    = 1'b0;
      setTimeout = 1'b0;
      state_d    = S_IDLE;
    end
  end

  // Sticky flags: a new set event beats a simultaneous write-one-to-clear.
  assign done_d    = setDone    | (done_q    & ~(statWr & avs_writedata_i[1]));
  assign timeout_d = setTimeout | (timeout_q & ~(statWr & avs_writedata_i[2]));

  always_comb begin
    readdata_d = 32'h0;
    if (avs_read_i) begin
      case (avs_address_i)
        2'd0:    readdata_d = {29'h0, irqEnBit, 2'b00};
        2'd1:    readdata_d = {29'h0, timeout_q, done_q, state_q != S_IDLE};
        2'd2:    readdata_d = pixLoaded_q;
        default: readdata_d = resSent_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      pixLoaded_q <= '0;
      resSent_q   <= '0;
      burstIdx_q  <= '0;
      wdCnt_q     <= '0;
      detPixel_q  <= '0;
      readdata_q  <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pixLoaded_q <= pixLoaded_d;
      resSent_q   <= resSent_d;
      burstIdx_q  <= burstIdx_d;
      wdCnt_q     <= wdCnt_d;
      detPixel_q  <= detPixel_d;
      readdata_q  <= readdata_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < N; i++) buffer_q[i] <= 8'h00;
    end else if (loadBeat) begin
      buffer_q[pixLoaded_q[IDX_W-1:0]] <= snk_data_i;
    end
  end

`ifdef EDGE_CTRL_IRQ_EN
  logic irqEn_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)      irqEn_q <= 1'b0;
    else if (ctrlWr) irqEn_q <= avs_writedata_i[2];
  end

  assign irqEnBit = irqEn_q;
  assign irq_o    = irqEn_q & (done_q | timeout_q);
`else
  assign irqEnBit = 1'b0;
  assign irq_o    = 1'b0;
`endif

  assign det_pixel_o    = detPixel_q;
  assign avs_readdata_o = readdata_q;

endmodule

// File: tb/tb_edge_detector_ctrl.sv
// tb_edge_detector_ctrl: directed, table-driven bench for edge_detector_ctrl (3x3 frame, 1 result, 16-cycle watchdog).
// Interrupt expectations follow EDGE_CTRL_IRQ_EN, matching the build of the design.
module tb_edge_detector_ctrl;

`ifdef EDGE_CTRL_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  avsAddress = 2'd0;
  logic        avsWrite = 1'b0;
  logic [31:0] avsWritedata = 32'h0;
  logic        avsRead = 1'b0;
  logic [31:0] avsReaddata;
  logic        snkValid = 1'b0;
  logic [7:0]  snkData = 8'h00;
  logic        snkReady;
  logic        detStart;
  logic [7:0]  detPixelOut;
  logic        detAvail = 1'b0;
  logic        detValid = 1'b0;
  logic [7:0]  detPixelIn = 8'h00;
  logic        srcValid;
  logic [7:0]  srcData;
  logic        irq;

  int total = 0;
  int bad = 0;
  int startPulses = 0;
  int srcPulses = 0;

  edge_detector_ctrl #(
    .IMG_X_SIZE(3), .IMG_Y_SIZE(3), .OUT_PIXELS(1), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk), .rst_i(rst_n),
    .avs_address_i(avsAddress), .avs_write_i(avsWrite), .avs_writedata_i(avsWritedata),
    .avs_read_i(avsRead), .avs_readdata_o(avsReaddata),
    .snk_valid_i(snkValid), .snk_data_i(snkData), .snk_ready_o(snkReady),
    .det_start_o(detStart), .det_pixel_o(detPixelOut),
    .det_data_available_i(detAvail), .det_valid_i(detValid), .det_pixel_i(detPixelIn),
    .src_valid_o(srcValid), .src_data_o(srcData), .irq_o(irq)
  );

  always #5 clk = ~clk;

  // Pulse counters sample well after the falling edge, once all driven inputs have settled.
  always begin
    @(negedge clk);
    #3;
    if (detStart) startPulses++;
    if (srcValid) srcPulses++;
  end

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } regVec_t;

  regVec_t regTable[12];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sv, input logic [7:0] sd, input logic av,
                               input logic dv, input logic [7:0] dp);
    snkValid   = sv;
    snkData    = sd;
    detAvail   = av;
    detValid   = dv;
    detPixelIn = dp;
  endtask

  task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
    avsAddress   = a;
    avsWritedata = d;
    avsWrite     = 1'b1;
    tick();
    avsWrite     = 1'b0;
    avsWritedata = 32'h0;
  endtask

  task automatic regRead(input logic [1:0] a, output logic [31:0] d);
    avsAddress = a;
    avsRead    = 1'b1;
    tick();
    d       = avsReaddata;
    avsRead = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    regRead(a, v);
    checkOutput(name, v, exp);
  endtask

  // Streams count pixels base, base+step, ...; an optional 2-cycle gap follows index gapAfter.
  task automatic streamPixels(input int count, input logic [7:0] base, input logic [7:0] step,
                              input int gapAfter);
    for (int i = 0; i < count; i++) begin
      applyStimulus(1'b1, base + step * 8'(i), 1'b0, 1'b0, 8'h00);
      tick();
      if (i == gapAfter) begin
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got hang expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    int startBefore;
    int srcBefore;

    regTable[0]  = '{1'b0, 2'd0, 32'h0, 32'h0};
    regTable[1]  = '{1'b0, 2'd1, 32'h0, 32'h0};
    regTable[2]  = '{1'b0, 2'd2, 32'h0, 32'h0};
    regTable[3]  = '{1'b0, 2'd3, 32'h0, 32'h0};
    regTable[4]  = '{1'b1, 2'd0, 32'h4, 32'h0};
    regTable[5]  = '{1'b0, 2'd0, 32'h0, {29'h0, IRQ_ON, 2'b00}};
    regTable[6]  = '{1'b1, 2'd1, 32'h6, 32'h0};
    regTable[7]  = '{1'b0, 2'd1, 32'h0, 32'h0};
    regTable[8]  = '{1'b1, 2'd2, 32'hFFFF, 32'h0};
    regTable[9]  = '{1'b0, 2'd2, 32'h0, 32'h0};
    regTable[10] = '{1'b1, 2'd3, 32'hFFFF, 32'h0};
    regTable[11] = '{1'b0, 2'd3, 32'h0, 32'h0};

    // Reset state of every output.
    #7;
    checkOutput("rst_snk_ready", 32'(snkReady), 32'h0);
    checkOutput("rst_det_start", 32'(detStart), 32'h0);
    checkOutput("rst_det_pixel", 32'(detPixelOut), 32'h0);
    checkOutput("rst_src_valid", 32'(srcValid), 32'h0);
    checkOutput("rst_src_data", 32'(srcData), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_readdata", avsReaddata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Register map vectors.
    for (int i = 0; i < 12; i++) begin
      if (regTable[i].wr) regWrite(regTable[i].addr, regTable[i].data);
      else readCheck($sformatf("reg_vec%0d", i), regTable[i].addr, regTable[i].exp);
    end

    // Full frame with a 2-cycle gap after the 4th pixel.
    regWrite(2'd0, 32'h5);
    checkOutput("load_snk_ready", 32'(snkReady), 32'h1);
    streamPixels(9, 8'd10, 8'd10, 3);
    checkOutput("start_pulse", 32'(detStart), 32'h1);
    checkOutput("start_snk_ready", 32'(snkReady), 32'h0);
    tick();
    checkOutput("burst_no_start", 32'(detStart), 32'h0);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("burst_pix%0d", i), 32'(detPixelOut), 32'(10 * (i + 1)));
      if (i < 8) tick();
    end
    tick();
    checkOutput("wait_pix_hold", 32'(detPixelOut), 32'd90);
    checkOutput("start_count", startPulses, 1);
    readCheck("pixels_loaded9", 2'd2, 32'd9);
    readCheck("status_busy", 2'd1, 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("drain_idle_src", 32'(srcValid), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    #1;
    checkOutput("drain_src_valid", 32'(srcValid), 32'h1);
    checkOutput("drain_src_data", 32'(srcData), 32'h5A);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    #1;
    checkOutput("done_src_low", 32'(srcValid), 32'h0);
    tick();
    checkOutput("done_irq", 32'(irq), 32'(IRQ_ON));
    readCheck("status_done", 2'd1, 32'h2);
    readCheck("results_sent1", 2'd3, 32'd1);
    checkOutput("src_count", srcPulses, 1);
    regWrite(2'd1, 32'h2);
    readCheck("done_cleared", 2'd1, 32'h0);
    checkOutput("irq_cleared", 32'(irq), 32'h0);

    // Silent detector: watchdog fires after exactly 16 cycles of WAIT_AVAIL.
    regWrite(2'd0, 32'h5);
    streamPixels(9, 8'd1, 8'd1, -1);
    repeat (10) tick();
    repeat (15) tick();
    readCheck("wd_cycle16_busy", 2'd1, 32'h1);
    readCheck("wd_timeout", 2'd1, 32'h4);
    checkOutput("wd_irq", 32'(irq), 32'(IRQ_ON));
    regWrite(2'd1, 32'h4);
    readCheck("wd_cleared", 2'd1, 32'h0);

    // Abort mid-load; GO while busy is ignored; GO+ABORT stays idle.
    regWrite(2'd0, 32'h5);
    streamPixels(2, 8'd1, 8'd1, -1);
    regWrite(2'd0, 32'h5);
    readCheck("go_ignored_cnt", 2'd2, 32'd2);
    streamPixels(3, 8'd3, 8'd1, -1);
    regWrite(2'd0, 32'h6);
    checkOutput("abort_snk_ready", 32'(snkReady), 32'h0);
    readCheck("abort_pixels5", 2'd2, 32'd5);
    readCheck("abort_status", 2'd1, 32'h0);
    regWrite(2'd0, 32'h7);
    readCheck("goabort_idle", 2'd1, 32'h0);
    readCheck("goabort_cnt", 2'd2, 32'd5);
    regWrite(2'd0, 32'h5);
    checkOutput("restart_ready", 32'(snkReady), 32'h1);
    readCheck("restart_cnt0", 2'd2, 32'd0);

    // Reset asserted mid-burst, then a fresh frame.
    streamPixels(9, 8'd1, 8'd1, -1);
    tick();
    tick();
    startBefore = startPulses;
    srcBefore   = srcPulses;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_det_pixel", 32'(detPixelOut), 32'h0);
    checkOutput("midrst_det_start", 32'(detStart), 32'h0);
    checkOutput("midrst_snk_ready", 32'(snkReady), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("rel_irq", 32'(irq), 32'h0);
    checkOutput("rel_start_count", startPulses, startBefore);
    readCheck("rel_status", 2'd1, 32'h0);
    readCheck("rel_pixels", 2'd2, 32'h0);
    readCheck("rel_ctrl", 2'd0, 32'h0);
    regWrite(2'd0, 32'h5);
    streamPixels(9, 8'h11, 8'h11, -1);
    checkOutput("fresh_start", 32'(detStart), 32'h1);
    tick();
    checkOutput("fresh_pix_first", 32'(detPixelOut), 32'h11);
    repeat (8) tick();
    checkOutput("fresh_pix_last", 32'(detPixelOut), 32'h99);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hC3);
    #1;
    checkOutput("fresh_src_data", 32'(srcData), 32'hC3);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    readCheck("fresh_status", 2'd1, 32'h2);
    readCheck("fresh_results", 2'd3, 32'd1);
    checkOutput("fresh_irq", 32'(irq), 32'(IRQ_ON));
    checkOutput("fresh_src_count", srcPulses, srcBefore + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
